// File: rtl/pipelined_ks_subtractor_24bit_if.sv
// Operand/result handshake bundle for the pipelined Kogge-Stone subtractor.
// master drives in_valid/A/B/bin/out_ready; slave drives in_ready/out_valid/D/bout.
interface pipelined_ks_subtractor_24bit_if #(
    parameter int width = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] A;
    logic [width-1:0] B;
    logic             bin;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] D;
    logic             bout;

    modport master (
        output in_valid, A, B, bin, out_ready,
        input  in_ready, out_valid, D, bout
    );

    modport slave (
        input  in_valid, A, B, bin, out_ready,
        output in_ready, out_valid, D, bout
    );
endinterface

// File: rtl/pipelined_ks_subtractor_24bit.sv
// 3-stage Kogge-Stone subtractor: D = A - B - bin, bout = borrow out.
// Ports: clk, rst (sync, active-high), bus (slave side of the handshake bundle).
module pipelined_ks_subtractor_24bit #(
    parameter int width = 24
) (
    input logic clk,
    input logic rst,
    pipelined_ks_subtractor_24bit_if.slave bus
);
    localparam int LEVELS = $clog2(width);
    localparam int L_S2   = (LEVELS + 1) / 2;

    // Prefix levels [lo, hi): generate half.
    function automatic logic [width-1:0] ks_g(
        input logic [width-1:0] g,
        input logic [width-1:0] p,
        input int               lo,
        input int               hi
    );
        logic [width-1:0] ng;
        logic [width-1:0] np;
        for (int l = lo; l < hi; l++) begin
            ng = g;
            np = p;
            for (int i = (1 << l); i < width; i++) begin
                ng[i] = g[i] | (p[i] & g[i - (1 << l)]);
                np[i] = p[i] & p[i - (1 << l)];
            end
            g = ng;
            p = np;
        end
        return g;
    endfunction

    // Prefix levels [lo, hi): propagate half.
    function automatic logic [width-1:0] ks_p(
        input logic [width-1:0] p,
        input int               lo,
        input int               hi
    );
        logic [width-1:0] np;
        for (int l = lo; l < hi; l++) begin
            np = p;
            for (int i = (1 << l); i < width; i++)
                np[i] = p[i] & p[i - (1 << l)];
            p = np;
        end
        return p;
    endfunction

    logic             r_v1, r_v2, r_v3;
    logic             w_adv1, w_adv2, w_adv3;
    logic             w_in_ready, w_accept;

    logic [width-1:0] r_g1, r_p1;
    logic             r_c1;
    logic [width-1:0] r_g2, r_pg2, r_x2;
    logic             r_c2;
    logic [width-1:0] r_d;
    logic             r_bout;

    logic [width-1:0] w_g0, w_p0;
    logic             w_cin;
    logic [width-1:0] w_g2, w_pg2, w_g3;
    logic [width-1:0] w_sum;

    assign w_adv3     = ~r_v3 | bus.out_ready;
    assign w_adv2     = ~r_v2 | w_adv3;
    assign w_adv1     = ~r_v1 | w_adv2;
    assign w_in_ready = ~rst & w_adv1;
    assign w_accept   = bus.in_valid & w_in_ready;

    // A - B - bin == A + ~B + ~bin; carry-in is folded into bit 0's
    // generate so the prefix tree spans exactly width positions.
    always_comb begin
        w_cin   = ~bus.bin;
        w_p0    = bus.A ^ ~bus.B;
        w_g0    = bus.A & ~bus.B;
        w_g0[0] = w_g0[0] | (w_p0[0] & w_cin);
    end

    assign w_g2  = ks_g(r_g1, r_p1, 0, L_S2);
    assign w_pg2 = ks_p(r_p1, 0, L_S2);
    assign w_g3  = ks_g(r_g2, r_pg2, L_S2, LEVELS);

    // Carry into bit i is the group generate of bits [i-1:0].
    always_comb begin
        w_sum              = r_x2;
        w_sum[0]           = r_x2[0] ^ r_c2;
        w_sum[width-1:1]   = r_x2[width-1:1] ^ w_g3[width-2:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1   <= 1'b0;
            r_v2   <= 1'b0;
            r_v3   <= 1'b0;
            r_d    <= '0;
            r_bout <= 1'b0;
        end else begin
            if (w_adv1) begin
                r_v1 <= w_accept;
                if (w_accept) begin
                    r_g1 <= w_g0;
                    r_p1 <= w_p0;
                    r_c1 <= w_cin;
                end
            end
            if (w_adv2) begin
                r_v2 <= r_v1;
                if (r_v1) begin
                    r_g2  <= w_g2;
                    r_pg2 <= w_pg2;
                    r_x2  <= r_p1;
                    r_c2  <= r_c1;
                end
            end
            if (w_adv3) begin
                r_v3 <= r_v2;
                if (r_v2) begin
                    r_d    <= w_sum;
                    r_bout <= ~w_g3[width-1];
                end
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_v3;
    assign bus.D         = r_d;
    assign bus.bout      = r_bout;
endmodule

// File: tb/tb_pipelined_ks_subtractor_24bit.sv
// Self-checking bench for pipelined_ks_subtractor_24bit.
// Random and directed beats checked against an arithmetic reference queue.
module tb_pipelined_ks_subtractor_24bit;
    localparam int W = 24;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pipelined_ks_subtractor_24bit_if #(.width(W)) bus ();

    pipelined_ks_subtractor_24bit #(.width(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic         d_rst, d_iv, d_bin, d_ordy;
    logic [W-1:0] d_a, d_b;
    logic         o_ir, o_ov, o_bout;
    logic [W-1:0] o_d;

    logic [W:0] expq[$];
    int         stampq[$];

    function automatic logic [W-1:0] rnd_w();
        logic [31:0] r;
        r = $urandom;
        return r[W-1:0];
    endfunction

    // Reference: plain integer subtraction, mod 2^W, borrow = A < B + bin.
    function automatic logic [W:0] golden(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic         bi
    );
        longint      da, db, diff;
        logic [63:0] u;
        da   = longint'(a);
        db   = longint'(b) + longint'(bi);
        diff = da - db;
        u    = diff;
        return {(da < db), u[W-1:0]};
    endfunction

    // Apply inputs at the falling edge, sample outputs 1ns later.
    task automatic tick();
        @(negedge clk);
        rst           = d_rst;
        bus.in_valid  = d_iv;
        bus.A         = d_a;
        bus.B         = d_b;
        bus.bin       = d_bin;
        bus.out_ready = d_ordy;
        #1;
        o_ir   = bus.in_ready;
        o_ov   = bus.out_valid;
        o_d    = bus.D;
        o_bout = bus.bout;
        cyc++;
    endtask

    task automatic test_reset();
        d_rst = 1'b1; d_iv = 1'b1; d_ordy = 1'b1;
        d_a = rnd_w(); d_b = rnd_w(); d_bin = 1'b0;
        tick();
        tick();
        checks++;
        if (o_ir !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_ready got %b want 0", o_ir);
        end
        d_rst = 1'b0; d_iv = 1'b0;
        tick();
        checks++;
        if (o_ov !== 1'b0) begin
            errors++;
            $display("FAIL rst_out_valid got %b want 0", o_ov);
        end
        checks++;
        if (o_d !== '0) begin
            errors++;
            $display("FAIL rst_D got %h want 0", o_d);
        end
        checks++;
        if (o_bout !== 1'b0) begin
            errors++;
            $display("FAIL rst_bout got %b want 0", o_bout);
        end
        checks++;
        if (o_ir !== 1'b1) begin
            errors++;
            $display("FAIL rst_release_ready got %b want 1", o_ir);
        end
    endtask

    task automatic test_directed();
        logic [W-1:0] ta[5] = '{24'h000005, 24'h000000, 24'hFFFFFF,
                                24'h000000, 24'hFFFFFF};
        logic [W-1:0] tb[5] = '{24'h000003, 24'h000000, 24'hFFFFFF,
                                24'h000001, 24'h000000};
        logic         tc[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic [W-1:0] td[5] = '{24'h000002, 24'hFFFFFF, 24'hFFFFFF,
                                24'hFFFFFF, 24'hFFFFFF};
        logic         te[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int start, lat;
        for (int k = 0; k < 5; k++) begin
            d_ordy = 1'b1; d_iv = 1'b1;
            d_a = ta[k]; d_b = tb[k]; d_bin = tc[k];
            tick();
            checks++;
            if (o_ir !== 1'b1) begin
                errors++;
                $display("FAIL dir%0d_accept got %b want 1", k, o_ir);
            end
            start = cyc;
            d_iv  = 1'b0;
            d_a   = rnd_w(); d_b = rnd_w();
            lat   = -1;
            for (int i = 0; i < 8 && lat < 0; i++) begin
                tick();
                if (o_ov === 1'b1) lat = cyc - start;
            end
            checks++;
            if (lat != 3) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want 3", k, lat);
            end
            checks++;
            if ({o_bout, o_d} !== {te[k], td[k]}) begin
                errors++;
                $display("FAIL dir%0d_result got %b/%h want %b/%h",
                         k, o_bout, o_d, te[k], td[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W:0] e;
        int nout = 0;
        int last = -1;
        expq.delete();
        stampq.delete();
        d_ordy = 1'b1;
        for (int i = 0; i < 15; i++) begin
            d_iv  = (i < 8);
            d_a   = rnd_w(); d_b = rnd_w();
            d_bin = $urandom_range(0, 1) == 1;
            tick();
            if (i < 8) begin
                checks++;
                if (o_ir !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready beat %0d got %b want 1", i, o_ir);
                end
            end
            if (o_ov === 1'b1) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_extra got %h want none", o_d);
                end else begin
                    e = expq.pop_front();
                    if ({o_bout, o_d} !== e ||
                        cyc - stampq.pop_front() != 3 ||
                        (last >= 0 && cyc != last + 1)) begin
                        errors++;
                        $display("FAIL b2b_out %0d got %h at %0d want %h",
                                 nout, {o_bout, o_d}, cyc, e);
                    end
                end
                last = cyc;
                nout++;
            end
            if (d_iv && o_ir) begin
                expq.push_back(golden(d_a, d_b, d_bin));
                stampq.push_back(cyc);
            end
        end
        checks++;
        if (nout != 8) begin
            errors++;
            $display("FAIL b2b_count got %0d want 8", nout);
        end
    endtask

    task automatic test_backpressure();
        logic [W:0] held, e;
        logic       have = 1'b0;
        int acc = 0;
        int got = 0;
        int newb = 0;
        expq.delete();
        d_ordy = 1'b0; d_iv = 1'b1;
        for (int i = 0; i < 6; i++) begin
            d_a = rnd_w(); d_b = rnd_w();
            d_bin = $urandom_range(0, 1) == 1;
            tick();
            if (o_ov === 1'b1) begin
                if (have) begin
                    checks++;
                    if ({o_bout, o_d} !== held) begin
                        errors++;
                        $display("FAIL bp_hold got %h want %h",
                                 {o_bout, o_d}, held);
                    end
                end
                held = {o_bout, o_d};
                have = 1'b1;
            end
            if (o_ir) begin
                acc++;
                expq.push_back(golden(d_a, d_b, d_bin));
            end
        end
        checks++;
        if (acc != 3 || o_ir !== 1'b0) begin
            errors++;
            $display("FAIL bp_fill got %0d/%b want 3/0", acc, o_ir);
        end
        d_ordy = 1'b1;
        for (int i = 0; i < 12 && expq.size() > 0; i++) begin
            d_iv = (newb == 0);
            d_a = rnd_w(); d_b = rnd_w();
            d_bin = $urandom_range(0, 1) == 1;
            tick();
            if (o_ov === 1'b1) begin
                checks++;
                e = expq.pop_front();
                if ({o_bout, o_d} !== e) begin
                    errors++;
                    $display("FAIL bp_drain %0d got %h want %h",
                             got, {o_bout, o_d}, e);
                end
                got++;
            end
            if (d_iv && o_ir) begin
                expq.push_back(golden(d_a, d_b, d_bin));
                newb++;
            end
        end
        checks++;
        if (got != 4 || expq.size() != 0) begin
            errors++;
            $display("FAIL bp_count got %0d left %0d want 4 left 0",
                     got, expq.size());
        end
    endtask

    task automatic test_reset_mid();
        d_ordy = 1'b1; d_iv = 1'b1;
        for (int i = 0; i < 2; i++) begin
            d_a = rnd_w() | 24'h1; d_b = rnd_w(); d_bin = 1'b0;
            tick();
        end
        d_iv = 1'b0; d_rst = 1'b1;
        tick();
        checks++;
        if (o_ir !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_ready got %b want 0", o_ir);
        end
        d_rst = 1'b0;
        tick();
        checks++;
        if (o_ov !== 1'b0 || o_d !== '0 || o_bout !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_out got %b/%h/%b want 0/0/0",
                     o_ov, o_d, o_bout);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (o_ov !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_stale cycle %0d got %b want 0",
                         i, o_ov);
            end
        end
        expq.delete();
    endtask

    task automatic test_random();
        logic [W:0] e;
        logic [W+1:0] prev = '0;
        logic         stalled = 1'b0;
        int nin = 0;
        int nout = 0;
        expq.delete();
        for (int i = 0; i < 20000; i++) begin
            if (nin >= 1000 && expq.size() == 0) break;
            d_iv   = (nin < 1000) && ($urandom_range(0, 3) != 0);
            d_a    = rnd_w(); d_b = rnd_w();
            d_bin  = $urandom_range(0, 1) == 1;
            d_ordy = $urandom_range(0, 3) != 0;
            tick();
            if (stalled) begin
                checks++;
                if ({o_ov, o_bout, o_d} !== prev) begin
                    errors++;
                    $display("FAIL rnd_stall got %h want %h",
                             {o_ov, o_bout, o_d}, prev);
                end
            end
            stalled = (o_ov === 1'b1) && !d_ordy;
            prev    = {o_ov, o_bout, o_d};
            if (o_ov === 1'b1 && d_ordy) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL rnd_extra got %h want none", o_d);
                end else begin
                    e = expq.pop_front();
                    if ({o_bout, o_d} !== e) begin
                        errors++;
                        $display("FAIL rnd_out %0d got %h want %h",
                                 nout, {o_bout, o_d}, e);
                    end
                end
                nout++;
            end
            if (d_iv && o_ir) begin
                expq.push_back(golden(d_a, d_b, d_bin));
                nin++;
            end
        end
        checks++;
        if (nin != 1000 || nout != nin) begin
            errors++;
            $display("FAIL rnd_count got in %0d out %0d want 1000/1000",
                     nin, nout);
        end
    endtask

    initial begin
        d_rst = 1'b1; d_iv = 1'b0; d_ordy = 1'b1;
        d_a = '0; d_b = '0; d_bin = 1'b0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipelined_ks_subtractor_24bit.md
PIPELINED_KS_SUBTRACTOR_24BIT -- requirements
Module: pipelined_ks_subtractor_24bit

Interface
REQ-001 The block SHALL provide parameter: width, default 24, operand and difference bit width (legal range 8..32).
REQ-002 The block SHALL provide port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL provide port: rst  input  1  reset; synchronous, active-high.
REQ-004 The block SHALL provide port: in_valid  input  1  operand beat offered.
REQ-005 The block SHALL provide port: in_ready  output  1  block accepts the operand beat this cycle.
REQ-006 The block SHALL provide port: A  input  width  minuend.
REQ-007 The block SHALL provide port: B  input  width  subtrahend.
REQ-008 The block SHALL provide port: bin  input  1  borrow input.
REQ-009 The block SHALL provide port: out_valid  output  1  result beat offered.
REQ-010 The block SHALL provide port: out_ready  input  1  downstream accepts the result beat.
REQ-011 The block SHALL provide port: D  output  width  difference.
REQ-012 The block SHALL provide port: bout  output  1  borrow output.

Function
REQ-013 A beat SHALL transfer on input when in_valid and in_ready are both 1 at a clk edge, and on output when out_valid and out_ready are both 1.
REQ-014 Result arithmetic SHALL be D = (A - B - bin) mod 2^width, with bout = 1 exactly when A < B + bin (unsigned compare, width+1 bits).
REQ-015 The datapath SHALL be computed as A + ~B + ~bin using a Kogge-Stone parallel-prefix carry network, with bout = inverted carry-out; no behavioural "-" operator on the full width.
REQ-016 The block SHALL use exactly three register stages: S1 = registered bitwise generate/propagate plus carry-in; S2 = prefix levels 1..ceil(log2(width))/2 (rounded up); S3 = remaining prefix levels, sum and bout registered to the outputs.
REQ-017 Each stage SHALL carry one valid bit; with out_ready held at 1, a beat accepted at edge N SHALL appear on D/bout with out_valid=1 after edge N+3 (latency 3 cycles).
REQ-018 Throughput SHALL be one beat per cycle whenever out_ready is 1 continuously; no bubbles inserted.
REQ-019 Stage k SHALL advance when it is empty or the next stage advances; S3 advances when out_valid=0 or out_ready=1; in_ready = ~S1.valid | S1 advances (combinational ready chain permitted, no combinational path from in_valid to in_ready).
REQ-020 While out_valid=1 and out_ready=0, D, bout and out_valid SHALL hold stable, and no beat SHALL be lost, duplicated or reordered.
REQ-021 With all three stages full and out_ready=0, in_ready SHALL be 0; the pipeline SHALL hold at most 3 beats.
REQ-022 Simultaneous output drain and input accept on a full pipeline SHALL be legal in the same cycle (every stage shifts by one).
REQ-023 A, B, bin SHALL be sampled only on an accepted input beat; values when in_valid=0 or in_ready=0 SHALL have no effect.
REQ-024 Wrap-around: operands at any value, including all-zeros and all-ones, SHALL produce correct modular results; no saturation.

Reset
REQ-025 While rst=1 at a clk edge, all stage valid bits SHALL clear; out_valid=0, D=0, bout=0 from the following cycle.
REQ-026 in_ready SHALL be 0 during any cycle in which rst=1 and SHALL be 1 on the first cycle after rst deasserts.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight beats; none SHALL appear on the output after reset releases.

Verification
REQ-028 Scenario: width=24, A=0x000005, B=0x000003, bin=0, out_ready=1 -> after 3 cycles D=0x000002, bout=0.
REQ-029 Scenario: A=0x000000, B=0x000000, bin=1 -> D=0xFFFFFF, bout=1; A=0xFFFFFF, B=0xFFFFFF, bin=1 -> D=0xFFFFFF, bout=1.
REQ-030 Scenario: 8 back-to-back beats with out_ready=1 -> 8 consecutive out_valid cycles, in-order, latency 3, in_ready never drops.
REQ-031 Scenario: out_ready=0 with in_valid=1 continuously -> exactly 3 beats accepted then in_ready=0; D held stable; on out_ready=1 all 3 drain in order followed by the next beat.
REQ-032 Scenario: 2 beats in flight, rst pulsed 1 cycle -> out_valid=0, D=0, bout=0 afterwards, no stale beat emerges.
REQ-033 Scenario: 1000 random A, B, bin with random out_ready toggling -> every output matches {bout, D} golden from REQ-014, count of outputs equals count of accepted inputs.
